vga_ordered_dither: RTL and testbench

- Video output stage directly downstream of the ZPUTest VGA outputs (vga_red/green/blue, vga_hsync, vga_vsync, vga_window).
- Reduces inbits-per-channel colour to outbits-per-channel for narrow board DACs using 4x4 ordered (Bayer) dithering.
- Tracks raster position from sync edges, so it needs no timing parameters.
- Delays syncs and the window to match pixel latency, so the outputs drive VGA pins directly.

---
 rtl/vga_dither_pkg.sv | 41 ++++
 rtl/vga_raster_tracker.sv | 57 +++++
 rtl/vga_ordered_dither.sv | 97 +++++++++
 tb/tb_vga_ordered_dither.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_dither_pkg.sv
// Shared constants and the per-channel quantiser for the ordered-dither
// VGA output stage: Bayer threshold matrix, pipeline depth and the
// quantise/compare/saturate rule applied identically to R, G and B.
package vga_dither_pkg;

  // Colour, syncs and window all leave the block this many clocks after entry.
  localparam int PIPE_LAT = 2;

  // 4x4 Bayer thresholds, indexed [row y][column x].
  localparam logic [3:0] BAYER [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  // Keep the top outb bits of an inb-bit sample and round up by one LSB
  // when the next four discarded bits exceed the threshold.  The result
  // clamps at full scale so a bright pixel never wraps to black.  Widths
  // are elaboration constants, so every shift below is a fixed rewire.
  function automatic logic [15:0] dither_channel(input logic [15:0] in_val,
                                                 input logic [3:0]  t,
                                                 input int          inb,
                                                 input int          outb);
    int          d;
    logic [15:0] q;
    logic [15:0] low;
    logic [3:0]  f4;
    logic [15:0] sum;
    logic [15:0] sat;
    d   = inb - outb;
    q   = in_val >> d;
    low = in_val & ((16'd1 << d) - 16'd1);
    if (d >= 4) f4 = 4'(low >> (d - 4));
    else        f4 = 4'(low << (4 - d));
    sum = (f4 > t) ? q + 16'd1 : q;
    sat = (16'd1 << outb) - 16'd1;
    return (sum > sat) ? sat : sum;
  endfunction

endpackage

// File: rtl/vga_raster_tracker.sv
// Recovers the 2-bit dither position from the video generator's syncs so
// the dither stage needs no timing parameters.  x counts visible pixels in
// the line, y counts lines, frame counts vsyncs.
// Build option: TEMPORAL_DITHER_EN builds the frame counter; otherwise
// frame is tied to zero.
module vga_raster_tracker
  import vga_dither_pkg::*;
#(
  parameter logic sync_pol = 1'b0
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       vid_ena,
  output logic [1:0] x,
  output logic [1:0] y,
  output logic [1:0] frame
);

  logic hs_q;
  logic vs_q;
  logic hs_lead;
  logic vs_lead;

  // A leading edge is the step from the inactive to the active sync level.
  assign hs_lead = (hsync == sync_pol) && (hs_q != sync_pol);
  assign vs_lead = (vsync == sync_pol) && (vs_q != sync_pol);

  // Sync history and x/y position; clears win over increments.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      hs_q <= ~sync_pol;
      vs_q <= ~sync_pol;
      x    <= '0;
      y    <= '0;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
      if (hs_lead)      x <= '0;
      else if (vid_ena) x <= x + 2'd1;
      if (vs_lead)      y <= '0;
      else if (hs_lead) y <= y + 2'd1;
    end
  end

`ifdef TEMPORAL_DITHER_EN
  // Frame counter rotates the matrix origin once per vsync.
  always_ff @(posedge clk) begin
    if (!reset_in)    frame <= '0;
    else if (vs_lead) frame <= frame + 2'd1;
  end
`else
  assign frame = '0;
`endif

endmodule

// File: rtl/vga_ordered_dither.sv
// VGA output stage: reduces inbits-per-channel colour to outbits for narrow
// DACs with 4x4 ordered dithering.  Two-stage pipeline; syncs and window
// are delayed alongside the colour so outputs can drive pins directly.
// Build option: TEMPORAL_DITHER_EN offsets the matrix index by the frame
// count (handled inside the raster tracker; frame reads zero otherwise).
module vga_ordered_dither
  import vga_dither_pkg::*;
#(
  parameter int   inbits   = 8,
  parameter int   outbits  = 4,
  parameter logic sync_pol = 1'b0
) (
  input  logic               clk,
  input  logic               reset_in,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               vid_ena,
  input  logic [inbits-1:0]  iRed,
  input  logic [inbits-1:0]  iGreen,
  input  logic [inbits-1:0]  iBlue,
  output logic [outbits-1:0] oRed,
  output logic [outbits-1:0] oGreen,
  output logic [outbits-1:0] oBlue,
  output logic               ohsync,
  output logic               ovsync,
  output logic               ovid_ena
);

  logic [1:0]        x;
  logic [1:0]        y;
  logic [1:0]        frame;
  logic [1:0]        ix;
  logic [1:0]        iy;
  logic [inbits-1:0] red1;
  logic [inbits-1:0] green1;
  logic [inbits-1:0] blue1;
  logic [3:0]        t1;
  logic              hs1;
  logic              vs1;
  logic              ve1;

  vga_raster_tracker #(.sync_pol(sync_pol)) u_tracker (
    .clk      (clk),
    .reset_in (reset_in),
    .hsync    (hsync),
    .vsync    (vsync),
    .vid_ena  (vid_ena),
    .x        (x),
    .y        (y),
    .frame    (frame)
  );

  // Matrix index; frame is zero unless temporal dithering is built in.
  assign ix = x + {1'b0, frame[0]};
  assign iy = y + {1'b0, frame[1]};

  // Stage 1: capture the pixel, its threshold and the timing signals.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      red1   <= '0;
      green1 <= '0;
      blue1  <= '0;
      t1     <= '0;
      hs1    <= ~sync_pol;
      vs1    <= ~sync_pol;
      ve1    <= 1'b0;
    end else begin
      red1   <= iRed;
      green1 <= iGreen;
      blue1  <= iBlue;
      t1     <= BAYER[iy][ix];
      hs1    <= hsync;
      vs1    <= vsync;
      ve1    <= vid_ena;
    end
  end

  // Stage 2: dithered colour, forced black outside the visible window.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      oRed     <= '0;
      oGreen   <= '0;
      oBlue    <= '0;
      ohsync   <= ~sync_pol;
      ovsync   <= ~sync_pol;
      ovid_ena <= 1'b0;
    end else begin
      oRed     <= ve1 ? outbits'(dither_channel(16'(red1),   t1, inbits, outbits)) : '0;
      oGreen   <= ve1 ? outbits'(dither_channel(16'(green1), t1, inbits, outbits)) : '0;
      oBlue    <= ve1 ? outbits'(dither_channel(16'(blue1),  t1, inbits, outbits)) : '0;
      ohsync   <= hs1;
      ovsync   <= vs1;
      ovid_ena <= ve1;
    end
  end

endmodule

// File: tb/tb_vga_ordered_dither.sv
// Bench for vga_ordered_dither (inbits=8, outbits=4, active-low syncs).
// A behavioural model tracks raster position from sync edges and predicts
// every output two clocks after its input; directed sequences pin the
// model with hand-computed values, then random traffic exercises the rest.
module tb_vga_ordered_dither;

  localparam int IN  = 8;
  localparam int OUT = 4;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       hsync, vsync, vid_ena;
  logic [7:0] iRed, iGreen, iBlue;
  logic [3:0] oRed, oGreen, oBlue;
  logic       ohsync, ovsync, ovid_ena;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_ordered_dither #(.inbits(IN), .outbits(OUT), .sync_pol(1'b0)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .hsync    (hsync),
    .vsync    (vsync),
    .vid_ena  (vid_ena),
    .iRed     (iRed),
    .iGreen   (iGreen),
    .iBlue    (iBlue),
    .oRed     (oRed),
    .oGreen   (oGreen),
    .oBlue    (oBlue),
    .ohsync   (ohsync),
    .ovsync   (ovsync),
    .ovid_ena (ovid_ena)
  );

  int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  // Quantise by integer division; fraction is the next four bits below q.
  function automatic int dith(input int v, input int t);
    int d, q, r, f, o;
    d = IN - OUT;
    q = v / (2 ** d);
    r = v % (2 ** d);
    f = (d >= 4) ? r / (2 ** (d - 4)) : r * (2 ** (4 - d));
    o = q + ((f > t) ? 1 : 0);
    if (o > 2 ** OUT - 1) o = 2 ** OUT - 1;
    return o;
  endfunction

  // ---------------- behavioural model ----------------
  int   mx, my, mf, ix, iy, t;
  logic phs, pvs, hl, vl;
  bit   prev_valid = 0;
  bit   model_ready = 0;
  int   pr_r, pr_g, pr_b;
  logic pr_hs, pr_vs, pr_ve;
  int   e_r, e_g, e_b;
  logic e_hs, e_vs, e_ve;

  always @(posedge clk) begin
    if (!reset_in) begin
      e_r = 0; e_g = 0; e_b = 0; e_hs = 1'b1; e_vs = 1'b1; e_ve = 1'b0;
      mx = 0; my = 0; mf = 0; phs = 1'b1; pvs = 1'b1; prev_valid = 0;
    end else begin
      if (prev_valid) begin
        e_r = pr_r; e_g = pr_g; e_b = pr_b; e_hs = pr_hs; e_vs = pr_vs; e_ve = pr_ve;
      end else begin
        e_r = 0; e_g = 0; e_b = 0; e_hs = 1'b1; e_vs = 1'b1; e_ve = 1'b0;
      end
`ifdef TEMPORAL_DITHER_EN
      ix = (mx + (mf % 2)) % 4;
      iy = (my + (mf / 2) % 2) % 4;
`else
      ix = mx;
      iy = my;
`endif
      t = bayer[iy][ix];
      pr_ve = vid_ena;
      pr_hs = hsync;
      pr_vs = vsync;
      pr_r  = vid_ena ? dith(int'(iRed), t)   : 0;
      pr_g  = vid_ena ? dith(int'(iGreen), t) : 0;
      pr_b  = vid_ena ? dith(int'(iBlue), t)  : 0;
      hl = (hsync == 1'b0) && (phs == 1'b1);
      vl = (vsync == 1'b0) && (pvs == 1'b1);
      if (vl) begin my = 0; mf = (mf + 1) % 4; end
      else if (hl) my = (my + 1) % 4;
      if (hl) mx = 0;
      else if (vid_ena) mx = (mx + 1) % 4;
      phs = hsync;
      pvs = vsync;
      prev_valid = 1;
    end
    model_ready = 1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ready) begin
      checks++;
      if (oRed !== 4'(e_r) || oGreen !== 4'(e_g) || oBlue !== 4'(e_b) ||
          ohsync !== e_hs || ovsync !== e_vs || ovid_ena !== e_ve) begin
        failures++;
        $display("FAIL model_cmp t=%0t actual rgb=%h,%h,%h hs=%b vs=%b ve=%b expected rgb=%h,%h,%h hs=%b vs=%b ve=%b",
                 $time, oRed, oGreen, oBlue, ohsync, ovsync, ovid_ena,
                 4'(e_r), 4'(e_g), 4'(e_b), e_hs, e_vs, e_ve);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] s_r;
  logic       s_hs, s_vs, s_ve;
  int         got [4];
  int         pv [12];
  int         ph [12];

`ifdef TEMPORAL_DITHER_EN
  int line0_exp [4] = '{8, 9, 8, 9};
  int line1_exp [4] = '{9, 8, 9, 8};
`else
  int line0_exp [4] = '{9, 8, 9, 8};
  int line1_exp [4] = '{8, 9, 8, 9};
`endif

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Sample outputs of the cycle just ending, then drive the next inputs.
  task automatic step(input logic hs, input logic vs, input logic ve,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic rst);
    @(negedge clk);
    s_r  = oRed;
    s_hs = ohsync;
    s_vs = ovsync;
    s_ve = ovid_ena;
    hsync = hs; vsync = vs; vid_ena = ve;
    iRed = r; iGreen = g; iBlue = b;
    reset_in = rst;
  endtask

  task automatic hs_pulse();
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic vs_pulse();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  // Four visible pixels of one colour, then two blanks to flush the pipe.
  task automatic line(input logic [7:0] c);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, (i < 4), c, c, c, 1'b1);
      if (i >= 2) got[i-2] = int'(s_r);
    end
  endtask

  task automatic block4x4(input logic [7:0] c, input int exp, input string nm);
    hs_pulse();
    vs_pulse();
    for (int yy = 0; yy < 4; yy++) begin
      if (yy > 0) hs_pulse();
      line(c);
      for (int xx = 0; xx < 4; xx++) chk(nm, got[xx], exp);
    end
  endtask

  initial begin
    reset_in = 1'b0; hsync = 1'b1; vsync = 1'b1; vid_ena = 1'b1;
    iRed = 8'h80; iGreen = 8'h80; iBlue = 8'h80;

    // Reset with live inputs; outputs stay idle through two clocks after release.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'h80, 8'h80, 8'h80, (i >= 4));
      chk("reset_colour", int'(s_r), 0);
      chk("reset_vid", int'(s_ve), 0);
      chk("reset_hsync", int'(s_hs), 1);
      chk("reset_vsync", int'(s_vs), 1);
    end
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

    // 0x88: first two lines after vsync.
    hs_pulse();
    vs_pulse();
    line(8'h88);
    for (int i = 0; i < 4; i++) chk("line0_88", got[i], line0_exp[i]);
    hs_pulse();
    line(8'h88);
    for (int i = 0; i < 4; i++) chk("line1_88", got[i], line1_exp[i]);

    block4x4(8'h80, 8, "flat_80");
    block4x4(8'hFF, 15, "saturate_ff");

    // Window pulse at N, hsync leading edge at N+5.
    for (int j = 0; j < 12; j++) begin
      step((j == 5) ? 1'b0 : 1'b1, 1'b1, (j == 0), 8'h55, 8'hAA, 8'h3C, 1'b1);
      pv[j] = int'(s_ve);
      ph[j] = int'(s_hs);
    end
    chk("pulse_ve_n1", pv[1], 0);
    chk("pulse_ve_n2", pv[2], 1);
    chk("pulse_ve_n3", pv[3], 0);
    chk("pulse_hs_n6", ph[6], 1);
    chk("pulse_hs_n7", ph[7], 0);
    chk("pulse_hs_n8", ph[8], 1);

    // Random traffic with occasional syncs and mid-frame resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 11) != 0), ($urandom_range(0, 59) != 0),
           ($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 299) != 0));
    end
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
